keypad_debounce_encoder: RTL and testbench



---
 rtl/keypad_debounce_encoder.sv | 192 +++++++++++++++++++
 tb/tb_keypad_debounce_encoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce_encoder.sv
// Keypad sampler, highest-index priority encoder, debouncer and digit entry buffer.
// Optional macro KEYPAD_MULTIKEY_ERR_EN adds multi_err and rejects multi-key presses.
module keypad_debounce_encoder #(
   parameter  int N_KEYS          = 10,
   parameter  int CODE_W          = 4,
   parameter  int DEBOUNCE_CYCLES = 4,
   parameter  int NUM_DIGITS      = 4,
   localparam int CNT_W           = $clog2(NUM_DIGITS + 1)
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         enablen,
   input  logic [N_KEYS-1:0]            keypad,
   input  logic                         clear,
   output logic [CODE_W-1:0]            D,
   output logic                         key_valid,
   output logic                         key_held,
   output logic [NUM_DIGITS*CODE_W-1:0] digits,
   output logic [CNT_W-1:0]             digit_count
`ifdef KEYPAD_MULTIKEY_ERR_EN
   ,
   output logic                         multi_err
`endif
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED,
      RELEASE
   } state_t;

   state_t              state, state_n;
   logic [N_KEYS-1:0]   ks;
   logic [CODE_W-1:0]   cand, cand_n;
   logic [DB_W-1:0]     cnt, cnt_n;
   logic                accept;
   logic                none;
   logic [CODE_W-1:0]   code_ks;
   logic [NUM_DIGITS*CODE_W-1:0] shifted;

`ifdef KEYPAD_MULTIKEY_ERR_EN
   logic multi;
   logic err_lock, err_lock_n;
   logic err_n;
`endif

   // Highest set index wins; an all-zero vector encodes to 0 and is flagged by none.
   function automatic logic [CODE_W-1:0] prio_code(input logic [N_KEYS-1:0] v);
      logic [CODE_W-1:0] c;
      c = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (v[i]) c = CODE_W'(i);
      end
      return c;
   endfunction

   assign none    = (ks == '0);
   assign code_ks = prio_code(ks);
`ifdef KEYPAD_MULTIKEY_ERR_EN
   assign multi   = |(ks & (ks - N_KEYS'(1)));
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ks <= '0;
      end else begin
         ks <= keypad;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cand      <= '0;
         cnt       <= '0;
         D         <= '0;
         key_valid <= 1'b0;
      end else begin
         state     <= state_n;
         cand      <= cand_n;
         cnt       <= cnt_n;
         key_valid <= accept;
         if (accept) D <= cand;
      end
   end

   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      accept  = 1'b0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
      err_n      = 1'b0;
      err_lock_n = none ? 1'b0 : err_lock;
`endif
      unique case (state)
         IDLE: begin
`ifdef KEYPAD_MULTIKEY_ERR_EN
            // A chord held across several cycles reports a single error pulse.
            if (multi) begin
               err_n      = !err_lock;
               err_lock_n = 1'b1;
            end else
`endif
            if (!none) begin
               cand_n  = code_ks;
               cnt_n   = DB_W'(1);
               state_n = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
`ifdef KEYPAD_MULTIKEY_ERR_EN
            if (multi) begin
               err_n      = !err_lock;
               err_lock_n = 1'b1;
               state_n    = IDLE;
            end else
`endif
            if (none || (code_ks != cand)) begin
               state_n = IDLE;
            end else if (cnt == DB_W'(DEBOUNCE_CYCLES)) begin
               state_n = PRESSED;
               accept  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (none) begin
               cnt_n   = DB_W'(1);
               state_n = RELEASE;
            end
         end
         RELEASE: begin
            // A key reappearing during release is the same press, never a new pulse.
            if (!none) begin
               state_n = PRESSED;
            end else if (cnt == DB_W'(DEBOUNCE_CYCLES)) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (enablen) begin
         state_n = IDLE;
         accept  = 1'b0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
         err_n   = 1'b0;
`endif
      end
   end

   assign key_held = (state == PRESSED) || (state == RELEASE);

`ifdef KEYPAD_MULTIKEY_ERR_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         multi_err <= 1'b0;
         err_lock  <= 1'b0;
      end else begin
         multi_err <= err_n;
         err_lock  <= err_lock_n;
      end
   end
`endif

   // The buffer takes the digit while key_valid is high, so D already holds it.
   if (NUM_DIGITS > 1) begin : g_shift
      assign shifted = {digits[(NUM_DIGITS-1)*CODE_W-1:0], D};
   end else begin : g_single
      assign shifted = D;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         digits      <= '0;
         digit_count <= '0;
      end else if (clear) begin
         digits      <= '0;
         digit_count <= '0;
      end else if (key_valid) begin
         digits <= shifted;
         if (digit_count != CNT_W'(NUM_DIGITS)) digit_count <= digit_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Scoreboarded bench for keypad_debounce_encoder: directed presses push expected pulses, a negedge monitor checks them.
module tb_keypad_debounce_encoder;

   localparam int N_KEYS = 10;
   localparam int CODE_W = 4;
   localparam int NUM_DIGITS = 4;
   localparam int CNT_W = $clog2(NUM_DIGITS + 1);

   logic                         clk = 1'b0;
   logic                         resetn;
   logic                         enablen;
   logic [N_KEYS-1:0]            keypad;
   logic                         clear;
   logic [CODE_W-1:0]            D;
   logic                         key_valid;
   logic                         key_held;
   logic [NUM_DIGITS*CODE_W-1:0] digits;
   logic [CNT_W-1:0]             digit_count;
`ifdef KEYPAD_MULTIKEY_ERR_EN
   logic                         multi_err;
   int                           n_err_pulses = 0;
`endif

   typedef struct {
      int code;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   keypad_debounce_encoder dut (
      .clk         (clk),
      .resetn      (resetn),
      .enablen     (enablen),
      .keypad      (keypad),
      .clear       (clear),
      .D           (D),
      .key_valid   (key_valid),
      .key_held    (key_held),
      .digits      (digits),
      .digit_count (digit_count)
`ifdef KEYPAD_MULTIKEY_ERR_EN
      ,
      .multi_err   (multi_err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (resetn === 1'b1 && key_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pulse: got pulse with D=%0d at cycle %0d, expected none", D, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pulse_code", 32'(D), 32'(e.code));
            chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
`ifdef KEYPAD_MULTIKEY_ERR_EN
      if (resetn === 1'b1 && multi_err === 1'b1) n_err_pulses++;
`endif
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_pulse(input int code, input int at);
      exp_t e;
      e.code = code;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   // Clean press: expected pulse six edges after the key is applied.
   task automatic press(input int k, input int hold, input int gap);
      keypad = N_KEYS'(1 << k);
      expect_pulse(k, cyc + 6);
      step(hold);
      keypad = '0;
      step(gap);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int m;
      resetn  = 1'b0;
      enablen = 1'b0;
      keypad  = '0;
      clear   = 1'b0;
      step(2);
      @(negedge clk);
      chk("reset_D", 32'(D), 32'(0));
      chk("reset_key_valid", 32'(key_valid), 32'(0));
      chk("reset_key_held", 32'(key_held), 32'(0));
      chk("reset_digits", 32'(digits), 32'(0));
      chk("reset_digit_count", 32'(digit_count), 32'(0));
      step(1);
      resetn = 1'b1;
      step(2);

      // Single key 3, then check release timing of key_held.
      keypad = 10'b0000001000;
      expect_pulse(3, cyc + 6);
      step(10);
      keypad = '0;
      m = cyc;
      step(5);
      @(negedge clk);
      chk("held_before_release_done", 32'(key_held), 32'(1));
      chk("held_cycle_ref", 32'(cyc - m), 32'(5));
      step(1);
      @(negedge clk);
      chk("held_after_release_done", 32'(key_held), 32'(0));
      chk("t1_D", 32'(D), 32'(3));
      chk("t1_digit0", 32'(digits[3:0]), 32'(3));
      chk("t1_count", 32'(digit_count), 32'(1));
      step(4);

      // Several keys at once.
      keypad = 10'b1001010010;
`ifndef KEYPAD_MULTIKEY_ERR_EN
      expect_pulse(9, cyc + 6);
`endif
      step(10);
      keypad = '0;
      step(8);
`ifdef KEYPAD_MULTIKEY_ERR_EN
      chk("t2_err_pulses", 32'(n_err_pulses), 32'(1));
      chk("t2_D", 32'(D), 32'(3));
      chk("t2_digits", 32'(digits), 32'h0003);
      chk("t2_count", 32'(digit_count), 32'(1));
`else
      chk("t2_D", 32'(D), 32'(9));
      chk("t2_digits", 32'(digits), 32'h0039);
      chk("t2_count", 32'(digit_count), 32'(2));
`endif

      // Bouncing key 5, then stable.
      for (int i = 0; i < 3; i++) begin
         keypad = N_KEYS'(1 << 5);
         step(2);
         keypad = '0;
         step(2);
      end
      press(5, 10, 8);
      chk("t3_D", 32'(D), 32'(5));

      // Clear, then five presses saturate the buffer.
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      chk("t4_clear_digits", 32'(digits), 32'(0));
      chk("t4_clear_count", 32'(digit_count), 32'(0));
      for (int k = 1; k <= 5; k++) begin
         press(k, 8, 8);
         if (k == 1) chk("t4_count_first", 32'(digit_count), 32'(1));
      end
      chk("t4_digits", 32'(digits), 32'h2345);
      chk("t4_count", 32'(digit_count), 32'(4));

      // Clear coincides with the key_valid of key 7.
      keypad = N_KEYS'(1 << 7);
      expect_pulse(7, cyc + 6);
      step(6);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      @(negedge clk);
      chk("t5_digits", 32'(digits), 32'(0));
      chk("t5_count", 32'(digit_count), 32'(0));
      chk("t5_D", 32'(D), 32'(7));
      step(1);
      keypad = '0;
      step(8);

      // Disabled while key 6 held, then enabled with key still down.
      enablen = 1'b1;
      keypad  = N_KEYS'(1 << 6);
      step(12);
      @(negedge clk);
      chk("t6_D_hold", 32'(D), 32'(7));
      chk("t6_held_disabled", 32'(key_held), 32'(0));
      step(1);
      enablen = 1'b0;
      expect_pulse(6, cyc + 5);
      step(8);
      chk("t6_D", 32'(D), 32'(6));
      keypad = '0;
      step(8);

      // Asynchronous reset while key 2 is in PRESSED.
      keypad = N_KEYS'(1 << 2);
      expect_pulse(2, cyc + 6);
      step(8);
      chk("t7_held_pre", 32'(key_held), 32'(1));
      #1;
      resetn = 1'b0;
      #1;
      chk("t7_rst_D", 32'(D), 32'(0));
      chk("t7_rst_key_valid", 32'(key_valid), 32'(0));
      chk("t7_rst_key_held", 32'(key_held), 32'(0));
      chk("t7_rst_digits", 32'(digits), 32'(0));
      chk("t7_rst_count", 32'(digit_count), 32'(0));
      @(posedge clk);
      #3;
      resetn = 1'b1;
      expect_pulse(2, cyc + 6);
      step(10);
      chk("t7_D_after", 32'(D), 32'(2));
      chk("t7_digits_after", 32'(digits), 32'h0002);
      chk("t7_count_after", 32'(digit_count), 32'(1));
      keypad = '0;
      step(8);

      chk("pending_pulses", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
